// File: rtl/io_input_ctrl.sv
// Board input controller: synchronises switches and a push-button, debounces the button
// and exposes status/snapshot/live/count registers over MMIO. Define IO_INPUT_DEBOUNCE_EN
// to enable the debounce FSM; otherwise the synchronised button is used directly.
module io_input_ctrl #(
    parameter int unsigned DB_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  switches_in,
    input  logic        button_in,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        btn_level,
    output logic        btn_pulse
);

    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : gen_bad_cfg
        $error("DB_CYCLES must be within 1..255");
    end

    logic [1:0] btn_sync_q;
    logic [7:0] sw_meta_q, sw_sync_q;
    logic       btn_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_sync_q <= 2'b00;
            sw_meta_q  <= 8'h00;
            sw_sync_q  <= 8'h00;
        end else begin
            btn_sync_q <= {btn_sync_q[0], button_in};
            sw_meta_q  <= switches_in;
            sw_sync_q  <= sw_meta_q;
        end
    end

    assign btn_s = btn_sync_q[1];

`ifdef IO_INPUT_DEBOUNCE_EN
    typedef enum logic [1:0] {StLo, StWaitHi, StHi, StWaitLo} db_state_e;

    localparam logic [7:0] CntLast = 8'(DB_CYCLES - 1);

    db_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StLo;
            cnt_q   <= 8'h00;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // >= keeps DB_CYCLES=1 from counting past the limit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StLo: begin
                if (btn_s) begin
                    state_d = StWaitHi;
                    cnt_d   = 8'd1;
                end
            end
            StWaitHi: begin
                if (!btn_s) begin
                    state_d = StLo;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= CntLast) begin
                    state_d = StHi;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHi: begin
                if (!btn_s) begin
                    state_d = StWaitLo;
                    cnt_d   = 8'd1;
                end
            end
            StWaitLo: begin
                if (btn_s) begin
                    state_d = StHi;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= CntLast) begin
                    state_d = StLo;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
        // A release bounce returning to HI is not a new press
        pulse_d = (state_q == StWaitHi) && (state_d == StHi);
    end

    assign btn_level = (state_q == StHi);
    assign btn_pulse = pulse_q;
`else
    logic btn_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_s;
        end
    end

    assign btn_level = btn_s;
    assign btn_pulse = btn_s & ~btn_prev_q;
`endif

    logic [7:0] snap_q, snap_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;
    logic       rd_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q      <= 8'h00;
            press_cnt_q <= 8'h00;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            press_cnt_q <= press_cnt_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    // A snapshot read racing a press keeps the new event pending but drops overrun
    always_comb begin
        snap_d      = snap_q;
        press_cnt_d = press_cnt_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        rd_clr      = rd_en && (rd_addr == 2'd1);
        if (btn_pulse) begin
            snap_d      = sw_sync_q;
            press_cnt_d = press_cnt_q + 8'd1;
            pending_d   = 1'b1;
            overrun_d   = overrun_q | pending_q;
        end
        if (rd_clr) begin
            overrun_d = 1'b0;
            if (!btn_pulse) begin
                pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = 32'h0;
        if (rd_en) begin
            unique case (rd_addr)
                2'd0: rd_data = {29'b0, btn_level, overrun_q, pending_q};
                2'd1: rd_data = {24'b0, snap_q};
                2'd2: rd_data = {24'b0, sw_sync_q};
                2'd3: rd_data = {24'b0, press_cnt_q};
            endcase
        end
    end

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 3: number of consecutive stable synchronized samples required to accept a button level change; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 switches_in  input  8  raw board switches, asynchronous to clk.
REQ-005 button_in  input  1  raw board push-button, asynchronous, bouncy.
REQ-006 rd_en  input  1  CPU MMIO read strobe, one cycle per access.
REQ-007 rd_addr  input  2  MMIO register select: 0 status, 1 snapshot, 2 live switches, 3 press count.
REQ-008 rd_data  output  32  MMIO read data, zero-extended.
REQ-009 btn_level  output  1  debounced button level.
REQ-010 btn_pulse  output  1  one-cycle strobe on each accepted press.

Function
REQ-011 button_in and switches_in SHALL each pass through a two-flop synchronizer before any other use.
REQ-012 Debounce FSM SHALL have states LO, WAIT_HI, HI, WAIT_LO; an 8-bit counter runs in the WAIT states only.
REQ-013 LO: sync=1 -> WAIT_HI, counter=1; HI: sync=0 -> WAIT_LO, counter=1.
REQ-014 WAIT_HI: sync=0 -> LO, counter=0 (bounce discarded); sync=1 and counter=DB_CYCLES-1 -> HI; otherwise counter+1 (WAIT_LO symmetric, returning to HI on bounce).
REQ-015 btn_level SHALL be 1 exactly in state HI; the first edge after button_in rises SHALL see btn_level rise after 2+DB_CYCLES clock edges of stable high input.
REQ-016 btn_pulse SHALL be high for exactly the one cycle in which the FSM enters HI; no pulse on the HI->LO transition.
REQ-017 On btn_pulse: snapshot <= synchronized switches; press_cnt (8-bit) <= press_cnt+1, wrapping 255->0; pending <= 1; if pending was already 1, overrun <= 1.
REQ-018 rd_data SHALL be combinational: rd_en=0 -> 0; addr0 -> {29'b0, btn_level, overrun, pending}; addr1 -> {24'b0, snapshot}; addr2 -> {24'b0, synchronized switches}; addr3 -> {24'b0, press_cnt}.
REQ-019 A read with rd_en=1 and rd_addr=1 SHALL clear pending and overrun on the following edge; reads of other addresses SHALL have no side effect.
REQ-020 Simultaneous addr1 read and btn_pulse: the read returns the old snapshot; new snapshot is stored; pending stays 1; overrun is cleared, not set.
REQ-021 Button held indefinitely SHALL produce exactly one pulse; counter SHALL never exceed DB_CYCLES.

Reset
REQ-022 While rst=0, all flops SHALL clear immediately: FSM=LO, counter=0, synchronizers=0, snapshot=0, press_cnt=0, pending=0, overrun=0; btn_level=0, btn_pulse=0, rd_data=0 when rd_en=0.
REQ-023 Reset asserted mid-debounce SHALL abort the WAIT state with no pulse; after release, a button already high SHALL be debounced afresh from LO and produce one pulse.

Configuration
REQ-024 Macro IO_INPUT_DEBOUNCE_EN defined: debounce FSM per REQ-012..REQ-014.
REQ-025 IO_INPUT_DEBOUNCE_EN undefined: btn_level SHALL equal the synchronized button directly (DB_CYCLES ignored), btn_pulse on its rising edge; latency 2 edges; all register behaviour unchanged.

Verification
REQ-026 Reset release, no input activity -> all reads return 0, btn_pulse never asserts.
REQ-027 DB_CYCLES=3, button_in high 5 cycles from edge 0 -> btn_level=1 at edge 5, one btn_pulse, press_cnt=1, pending=1.
REQ-028 Bounce 1,0,1,0 one cycle each, then stable 1 -> no pulse during bounce; exactly one pulse after 3 stable synced samples.
REQ-029 switches_in=8'h02, two presses without read -> status reads 3'b111 while held, snapshot=8'h02; addr1 read -> next status reads 3'b100 while held.
REQ-030 256 presses -> press_cnt wraps to 0; addr1 read coinciding with pulse -> old snapshot returned, pending=1, overrun=0.
REQ-031 Build without IO_INPUT_DEBOUNCE_EN, 1-cycle input glitch -> pulse asserted 2 edges later, press_cnt increments.
